// File: rtl/buma_pkg.sv
// Shared types and defaults for the buma_acc signed accumulator stage.
// States, default widths and the min/max seed values live here.
package buma_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    // Seed values so the first sample of a run always replaces both trackers.
    localparam logic [IN_W_DEF-1:0] MIN_INIT = 8'h7F;
    localparam logic [IN_W_DEF-1:0] MAX_INIT = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/buma_acc.sv
// Signed run accumulator: sums a run of len samples, tracks signed min/max
// and a sticky overflow flag, and pulses done once at the end of each run.
module buma_acc
    import buma_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum,
    output logic [CNT_W-1:0] count,
    output logic [IN_W-1:0]  min_val,
    output logic [IN_W-1:0]  max_val,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    // Seeds derived from IN_W so non-default widths keep the same meaning.
    localparam logic [IN_W-1:0] MIN_LOAD = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [IN_W-1:0] MAX_LOAD = {1'b1, {(IN_W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IN_W-1:0]    min_q, min_d;
    logic [IN_W-1:0]    max_q, max_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   sample_ext;
    logic [ACC_W-1:0]   add_res;
    logic               add_ovf;
    logic [CNT_W-1:0]   count_inc;

    always_comb begin
        sample_ext = ACC_W'($signed(in_data));
        add_res    = sum_q + sample_ext;
        // Overflow: like-signed operands producing an opposite-signed result.
        add_ovf    = (sum_q[ACC_W-1] == sample_ext[ACC_W-1]) &&
                     (add_res[ACC_W-1] != sum_q[ACC_W-1]);
        count_inc  = count_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        count_d = count_q;
        min_d   = min_q;
        max_d   = max_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    min_d   = MIN_LOAD;
                    max_d   = MAX_LOAD;
                    len_d   = len;
                    state_d = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    sum_d   = add_res;
                    count_d = count_inc;
                    ovf_d   = ovf_q | add_ovf;
                    if ($signed(in_data) < $signed(min_q)) min_d = in_data;
                    if ($signed(in_data) > $signed(max_q)) max_d = in_data;
                    if (count_inc == len_q) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            min_q   <= MIN_LOAD;
            max_q   <= MAX_LOAD;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            min_q   <= min_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign count     = count_q;
    assign min_val   = min_q;
    assign max_val   = max_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_buma_acc.sv
// Bench for buma_acc: a 16-bit and an 8-bit accumulator instance share one
// stimulus stream; results are checked against an arithmetic run model.
module tb_buma_acc;
    import buma_pkg::*;

    typedef struct packed {
        logic [15:0] sum16;
        logic        ovf16;
        logic [7:0]  sum8;
        logic        ovf8;
        logic [7:0]  cnt;
        logic [7:0]  mn;
        logic [7:0]  mx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;

    logic        busy16, done16, ovf16;
    logic [15:0] sum16;
    logic [7:0]  cnt16, min16, max16;
    logic [1:0]  st16;
    logic        busy8, done8, ovf8;
    logic [7:0]  sum8;
    logic [7:0]  cnt8, min8, max8;
    logic [1:0]  st8;

    exp_t        exp_q[$];
    logic [7:0]  samp_q[$];
    int          fixed_gap[$];
    int          n_vec = 0;
    int          n_err = 0;

    buma_acc u_dut16 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data),
        .busy(busy16), .done(done16), .sum(sum16), .count(cnt16),
        .min_val(min16), .max_val(max16), .overflow(ovf16), .dbg_state(st16)
    );

    buma_acc #(.ACC_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data),
        .busy(busy8), .done(done8), .sum(sum8), .count(cnt8),
        .min_val(min8), .max_val(max8), .overflow(ovf8), .dbg_state(st8)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer sum with wrap, overflow when a single
    // addition's true result leaves the accumulator's signed range.
    function automatic exp_t model(input int n);
        exp_t e;
        int a16 = 0;
        int a8 = 0;
        int mn = 127;
        int mx = -128;
        int s, t;
        e = '0;
        for (int i = 0; i < n; i++) begin
            s = int'($signed(samp_q[i]));
            t = a16 + s;
            if (t > 32767 || t < -32768) e.ovf16 = 1'b1;
            if (t > 32767) t -= 65536;
            if (t < -32768) t += 65536;
            a16 = t;
            t = a8 + s;
            if (t > 127 || t < -128) e.ovf8 = 1'b1;
            if (t > 127) t -= 256;
            if (t < -128) t += 256;
            a8 = t;
            if (s < mn) mn = s;
            if (s > mx) mx = s;
        end
        e.sum16 = 16'(a16);
        e.sum8  = 8'(a8);
        e.cnt   = 8'(n);
        e.mn    = 8'(mn);
        e.mx    = 8'(mx);
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy16"}, 32'(busy16), 32'd0);
        check({tag, "_done16"}, 32'(done16), 32'd0);
        check({tag, "_sum16"},  32'(sum16),  32'd0);
        check({tag, "_cnt16"},  32'(cnt16),  32'd0);
        check({tag, "_min16"},  32'(min16),  32'h7F);
        check({tag, "_max16"},  32'(max16),  32'h80);
        check({tag, "_ovf16"},  32'(ovf16),  32'd0);
        check({tag, "_st16"},   32'(st16),   32'(ST_IDLE));
        check({tag, "_sum8"},   32'(sum8),   32'd0);
        check({tag, "_done8"},  32'(done8),  32'd0);
    endtask

    // ---------------- driver ----------------
    // Called #1 after a rising edge; returns at the same phase.
    task automatic run_seq(input int n, input int gmax);
        int gaps;
        exp_q.push_back(model(n));
        start    = 1'b1;
        len      = 8'(n);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            gaps = (i < fixed_gap.size()) ? fixed_gap[i] : $urandom_range(0, gmax);
            repeat (gaps) begin
                in_valid = 1'b0;
                start    = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
                check("busy_in_gap", 32'(busy16), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = samp_q[i];
            start    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("done_after_last", 32'(done16), 32'd1);
        check("busy_low_in_done", 32'(busy16), 32'd0);
        // Junk sample and start during DONE must both be ignored.
        in_valid = 1'b1;
        in_data  = 8'($urandom_range(0, 255));
        start    = 1'b1;
        len      = 8'd5;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("idle_busy", 32'(busy16), 32'd0);
        check("idle_done", 32'(done16), 32'd0);
        check("idle_count_hold", 32'(cnt16), 32'(n));
        fixed_gap.delete();
    endtask

    task automatic fill_random(input int n, input int lo, input int hi);
        samp_q.delete();
        for (int i = 0; i < n; i++) samp_q.push_back(8'($urandom_range(lo, hi)));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && (done16 || done8)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done16=%0b done8=%0b, expected none", done16, done8);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done16", 32'(done16), 32'd1);
                check("done8",  32'(done8),  32'd1);
                check("sum16",  32'(sum16),  32'(e.sum16));
                check("ovf16",  32'(ovf16),  32'(e.ovf16));
                check("sum8",   32'(sum8),   32'(e.sum8));
                check("ovf8",   32'(ovf8),   32'(e.ovf8));
                check("count16", 32'(cnt16), 32'(e.cnt));
                check("count8",  32'(cnt8),  32'(e.cnt));
                check("min16",  32'(min16),  32'(e.mn));
                check("max16",  32'(max16),  32'(e.mx));
                check("min8",   32'(min8),   32'(e.mn));
                check("max8",   32'(max8),   32'(e.mx));
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int drain;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");

        samp_q = '{8'hC9, 8'h05, 8'h7F};
        run_seq(3, 0);

        samp_q = '{8'h10, 8'hF0};
        fixed_gap = '{0, 2};
        run_seq(2, 0);

        samp_q = '{8'h7F, 8'h01};
        fixed_gap = '{0, 0};
        run_seq(2, 0);
        samp_q = '{8'h01};
        run_seq(1, 0);

        samp_q.delete();
        run_seq(0, 0);

        // Abandoned run: reset after two samples, with an ignored mid-run start.
        fill_random(4, 0, 255);
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = samp_q[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b1; len = 8'd9;
        @(posedge clk); #1;
        check("midrun_start_count", 32'(cnt16), 32'd2);
        check("midrun_start_busy", 32'(busy16), 32'd1);
        start = 1'b0; reset = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check_reset_vals("abandon");
        @(posedge clk); #1;
        check("abandon_no_done", 32'(done16), 32'd0);

        for (int r = 0; r < 40; r++) begin
            fill_random($urandom_range(1, 12), 0, 255);
            run_seq(samp_q.size(), 2);
        end
        fill_random(60, 8'h60, 8'h7F);
        run_seq(60, 0);
        fill_random(60, 8'h80, 8'h9F);
        run_seq(60, 1);

        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(posedge clk); #1;
            drain++;
        end
        check("pending_results", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
